// File: rtl/axis_decimator.sv
// -----------------------------------------------------------------------------
// axis_decimator
//   Integer-factor AXI4-Stream decimator. Every DECIM-th accepted input sample
//   is kept, the others complete their handshake and are discarded. Kept samples
//   pass through a two-entry register slice (OUT + SKID), so both the output and
//   s_axis_tready are registered while full throughput is preserved.
//
// Parameters
//   DATA_WIDTH : TDATA width in bits (in and out)
//   DECIM      : decimation factor, >= 1 (1 = pass-through via the slice)
//   FRAME_LEN  : output samples per frame, >= 1 (TLAST build only)
//
// Ports
//   ACLK          in   clock, rising edge
//   ARESETn       in   asynchronous active-low reset
//   s_axis_tdata  in   input sample
//   s_axis_tvalid in   input valid
//   s_axis_tready out  input ready (registered)
//   m_axis_tdata  out  decimated sample
//   m_axis_tvalid out  output valid
//   m_axis_tready in   downstream ready
//   m_axis_tlast  out  last sample of a frame (only with AXIS_DECIMATOR_TLAST_EN)
//
// Build option
//   AXIS_DECIMATOR_TLAST_EN : adds m_axis_tlast and the output frame counter.
// -----------------------------------------------------------------------------
module axis_decimator #(
  parameter int DATA_WIDTH = 16,
  parameter int DECIM      = 4,
  parameter int FRAME_LEN  = 64
) (
  input  logic                  ACLK,
  input  logic                  ARESETn,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  input  logic                  s_axis_tvalid,
  output logic                  s_axis_tready,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready
`ifdef AXIS_DECIMATOR_TLAST_EN
  ,
  output logic                  m_axis_tlast
`endif
);

  if (DECIM < 1 || FRAME_LEN < 1) begin : g_bad_param
    $error("axis_decimator: DECIM and FRAME_LEN must both be >= 1");
  end

  localparam int            PW        = (DECIM > 1) ? $clog2(DECIM) : 1;
  localparam logic [PW-1:0] PHASE_MAX = PW'(DECIM - 1);

  logic [PW-1:0]         phase_q, phase_d;
  logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
  logic                  out_valid_q, out_valid_d;
  logic [DATA_WIDTH-1:0] skid_data_q, skid_data_d;
  logic                  skid_valid_q, skid_valid_d;
  logic                  ready_q;

  logic in_xfer;
  logic out_xfer;
  logic keep;
  logic to_out;

  assign in_xfer  = s_axis_tvalid & ready_q;
  assign out_xfer = out_valid_q & m_axis_tready;
  assign keep     = in_xfer & (phase_q == '0);
  // A kept sample may land straight in OUT when OUT is empty, or when OUT is
  // draining and there is no SKID entry that must go first.
  assign to_out   = ~out_valid_q | (out_xfer & ~skid_valid_q);

`ifdef AXIS_DECIMATOR_TLAST_EN
  localparam int            FW        = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
  localparam logic [FW-1:0] FRAME_MAX = FW'(FRAME_LEN - 1);

  logic [FW-1:0] frame_q, frame_d;
  logic          out_last_q, out_last_d;
  logic          skid_last_q, skid_last_d;
  logic          new_last;

  assign new_last = (frame_q == FRAME_MAX);
`endif

  // NOTE: every next-state variable gets its hold value first, so no path
  // through this block leaves one unassigned and no latch is inferred.
  always_comb begin
    phase_d      = phase_q;
    out_data_d   = out_data_q;
    out_valid_d  = out_valid_q;
    skid_data_d  = skid_data_q;
    skid_valid_d = skid_valid_q;
`ifdef AXIS_DECIMATOR_TLAST_EN
    frame_d      = frame_q;
    out_last_d   = out_last_q;
    skid_last_d  = skid_last_q;
`endif

    if (in_xfer) begin
      phase_d = (phase_q == PHASE_MAX) ? '0 : phase_q + PW'(1);
    end

    // Drain first: SKID, if occupied, refills OUT on the same edge.
    if (out_xfer) begin
      if (skid_valid_q) begin
        out_data_d   = skid_data_q;
        skid_valid_d = 1'b0;
`ifdef AXIS_DECIMATOR_TLAST_EN
        out_last_d   = skid_last_q;
`endif
      end else begin
        out_valid_d = 1'b0;
      end
    end

    if (keep) begin
      if (to_out) begin
        out_data_d  = s_axis_tdata;
        out_valid_d = 1'b1;
`ifdef AXIS_DECIMATOR_TLAST_EN
        out_last_d  = new_last;
`endif
      end else begin
        skid_data_d  = s_axis_tdata;
        skid_valid_d = 1'b1;
`ifdef AXIS_DECIMATOR_TLAST_EN
        skid_last_d  = new_last;
`endif
      end
`ifdef AXIS_DECIMATOR_TLAST_EN
      frame_d = new_last ? '0 : frame_q + FW'(1);
`endif
    end
  end

  // NOTE: state is updated with non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  // NOTE: the data registers are reset as well; m_axis_tdata must read 0
  // out of reset, and SKID is cleared alongside it for a clean restart.
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      phase_q      <= '0;
      out_data_q   <= '0;
      out_valid_q  <= 1'b0;
      skid_data_q  <= '0;
      skid_valid_q <= 1'b0;
      ready_q      <= 1'b0;
    end else begin
      phase_q      <= phase_d;
      out_data_q   <= out_data_d;
      out_valid_q  <= out_valid_d;
      skid_data_q  <= skid_data_d;
      skid_valid_q <= skid_valid_d;
      // Ready looks one edge ahead: accept only while SKID will be free.
      ready_q      <= ~skid_valid_d;
    end
  end

`ifdef AXIS_DECIMATOR_TLAST_EN
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      frame_q     <= '0;
      out_last_q  <= 1'b0;
      skid_last_q <= 1'b0;
    end else begin
      frame_q     <= frame_d;
      out_last_q  <= out_last_d;
      skid_last_q <= skid_last_d;
    end
  end

  assign m_axis_tlast = out_last_q;
`endif

  assign s_axis_tready = ready_q;
  assign m_axis_tdata  = out_data_q;
  assign m_axis_tvalid = out_valid_q;

endmodule

// File: tb/tb_axis_decimator.sv
// -----------------------------------------------------------------------------
// tb_axis_decimator
//   Directed bench for axis_decimator. Four instances with different DECIM
//   values share one clock and have independent resets:
//     u4 (DECIM=4) : rate / latency, then reset mid-stream
//     u1 (DECIM=1) : backpressure through the skid slice
//     u3 (DECIM=3) : random handshakes against a scoreboard queue
//     u2 (DECIM=2, FRAME_LEN=3) : impulse, and TLAST framing when enabled
//   Inputs are driven at the falling edge, outputs sampled just after it.
// -----------------------------------------------------------------------------
module tb_axis_decimator;

  localparam int DW = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // ---- per-instance signals ----
  logic          rst4, sv4, sr4, mv4, mr4;
  logic [DW-1:0] sd4, md4;
  logic          rst1, sv1, sr1, mv1, mr1;
  logic [DW-1:0] sd1, md1;
  logic          rst3, sv3, sr3, mv3, mr3;
  logic [DW-1:0] sd3, md3;
  logic          rst2, sv2, sr2, mv2, mr2;
  logic [DW-1:0] sd2, md2;
`ifdef AXIS_DECIMATOR_TLAST_EN
  logic ml4, ml1, ml3, ml2;
`endif

  axis_decimator #(.DATA_WIDTH(DW), .DECIM(4), .FRAME_LEN(64)) u4 (
    .ACLK(clk), .ARESETn(rst4),
    .s_axis_tdata(sd4), .s_axis_tvalid(sv4), .s_axis_tready(sr4),
    .m_axis_tdata(md4), .m_axis_tvalid(mv4), .m_axis_tready(mr4)
`ifdef AXIS_DECIMATOR_TLAST_EN
    , .m_axis_tlast(ml4)
`endif
  );

  axis_decimator #(.DATA_WIDTH(DW), .DECIM(1), .FRAME_LEN(64)) u1 (
    .ACLK(clk), .ARESETn(rst1),
    .s_axis_tdata(sd1), .s_axis_tvalid(sv1), .s_axis_tready(sr1),
    .m_axis_tdata(md1), .m_axis_tvalid(mv1), .m_axis_tready(mr1)
`ifdef AXIS_DECIMATOR_TLAST_EN
    , .m_axis_tlast(ml1)
`endif
  );

  axis_decimator #(.DATA_WIDTH(DW), .DECIM(3), .FRAME_LEN(64)) u3 (
    .ACLK(clk), .ARESETn(rst3),
    .s_axis_tdata(sd3), .s_axis_tvalid(sv3), .s_axis_tready(sr3),
    .m_axis_tdata(md3), .m_axis_tvalid(mv3), .m_axis_tready(mr3)
`ifdef AXIS_DECIMATOR_TLAST_EN
    , .m_axis_tlast(ml3)
`endif
  );

  axis_decimator #(.DATA_WIDTH(DW), .DECIM(2), .FRAME_LEN(3)) u2 (
    .ACLK(clk), .ARESETn(rst2),
    .s_axis_tdata(sd2), .s_axis_tvalid(sv2), .s_axis_tready(sr2),
    .m_axis_tdata(md2), .m_axis_tvalid(mv2), .m_axis_tready(mr2)
`ifdef AXIS_DECIMATOR_TLAST_EN
    , .m_axis_tlast(ml2)
`endif
  );

  // Impulse run on u2: 8 inputs, value 1 at index pos, zeros elsewhere.
  task automatic run_impulse(input int pos, output int ones, output int nout);
    ones = 0;
    nout = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      sv2 = (c < 8);
      sd2 = (c == pos) ? 16'd1 : 16'd0;
      #1;
      check("imp_ready", 32'(sr2), 32'd1);
      if (mv2 && mr2) begin
        nout++;
        if (md2 != 16'd0) begin
          ones++;
          check("imp_value", 32'(md2), 32'd1);
        end
      end
    end
    sv2 = 1'b0;
  endtask

  int q[$];

  initial begin
    logic a;
    logic acc;
    logic prev_stall;
    logic [DW-1:0] prev_data;
    int nacc, ones, nout, k;

    {rst4, rst1, rst3, rst2} = 4'b0000;
    {sv4, sv1, sv3, sv2} = 4'b0000;
    {mr4, mr1, mr3, mr2} = 4'b0000;
    sd4 = '0; sd1 = '0; sd3 = '0; sd2 = '0;

    // ---- reset state ----
    #2;
    check("rst_tready", 32'(sr4), 32'd0);
    check("rst_tvalid", 32'(mv4), 32'd0);
    check("rst_tdata",  32'(md4), 32'd0);
`ifdef AXIS_DECIMATOR_TLAST_EN
    check("rst_tlast",  32'(ml4), 32'd0);
`endif
    repeat (2) @(negedge clk);
    {rst4, rst1, rst3, rst2} = 4'b1111;
    #1;
    check("rst_tready_hold", 32'(sr4), 32'd0);
    @(negedge clk);
    check("tready_rise", 32'(sr1), 32'd1);

    // ---- DECIM=4 rate: ramp, sink always ready ----
    mr4 = 1'b1;
    sv4 = 1'b1;
    for (int i = 0; i < 16; i++) begin
      sd4 = 16'(i);
      @(negedge clk);
      check("rate_tready", 32'(sr4), 32'd1);
      check("rate_tvalid", 32'(mv4), 32'((i % 4) == 0));
      if (mv4) check("rate_tdata", 32'(md4), 32'(i));
    end
    sv4 = 1'b0;

    // ---- DECIM=1 backpressure ----
    sd1 = 16'd10;
    sv1 = 1'b1;
    mr1 = 1'b0;
    nacc = 0;
    for (int c = 0; c < 5; c++) begin
      a = sr1;
      @(negedge clk);
      if (a) begin
        nacc++;
        sd1 = sd1 + 16'd1;
      end
    end
    check("bp_accepted", 32'(nacc), 32'd2);
    check("bp_tready_low", 32'(sr1), 32'd0);
    check("bp_hold_valid", 32'(mv1), 32'd1);
    check("bp_hold_data", 32'(md1), 32'd10);
    mr1 = 1'b1;
    for (int c = 0; c < 10; c++) begin
      a = sr1;
      check("bp_rel_valid", 32'(mv1), 32'd1);
      check("bp_rel_data", 32'(md1), 32'(10 + c));
      @(negedge clk);
      if (a) sd1 = sd1 + 16'd1;
    end
    sv1 = 1'b0;

    // ---- DECIM=3 random handshakes ----
    acc = 1'b0;
    prev_stall = 1'b0;
    prev_data = '0;
    for (int c = 0; c < 1000; c++) begin
      @(negedge clk);
      if (acc) sd3 = sd3 + 16'd1;
      if (!sv3 || acc) sv3 = 1'($urandom_range(0, 1));
      mr3 = 1'($urandom_range(0, 1));
      #1;
      if (prev_stall) begin
        check("rand_stall_valid", 32'(mv3), 32'd1);
        check("rand_stall_data", 32'(md3), 32'(prev_data));
      end
      acc = sv3 & sr3;
      if (acc && (sd3 % 3) == 0) q.push_back(int'(sd3));
      if (mv3 && mr3) check("rand_order", 32'(md3), (q.size() > 0) ? 32'(q.pop_front()) : 32'hDEAD_BEEF);
      prev_stall = mv3 & ~mr3;
      prev_data = md3;
    end
    sv3 = 1'b0;
    mr3 = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      #1;
      if (mv3) check("rand_drain", 32'(md3), (q.size() > 0) ? 32'(q.pop_front()) : 32'hDEAD_BEEF);
    end
    check("rand_left", 32'(q.size()), 32'd0);

    // ---- DECIM=4 reset mid-stream ----
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      mr4 = (i < 4);
      sd4 = 16'(60 + i);
      sv4 = 1'b1;
    end
    @(negedge clk);
    sv4 = 1'b0;
    #1;
    check("mid_pending_valid", 32'(mv4), 32'd1);
    check("mid_pending_data", 32'(md4), 32'd64);
    #2;
    rst4 = 1'b0;
    #1;
    check("mid_async_valid", 32'(mv4), 32'd0);
    check("mid_async_tready", 32'(sr4), 32'd0);
    repeat (3) @(negedge clk);
    rst4 = 1'b1;
    @(negedge clk);
    check("mid_tready_back", 32'(sr4), 32'd1);
    sd4 = 16'd100;
    sv4 = 1'b1;
    mr4 = 1'b1;
    @(negedge clk);
    sv4 = 1'b0;
    #1;
    check("mid_first_valid", 32'(mv4), 32'd1);
    check("mid_first_data", 32'(md4), 32'd100);

    // ---- DECIM=2 impulse ----
    mr2 = 1'b1;
    run_impulse(4, ones, nout);
    check("imp_even_ones", 32'(ones), 32'd1);
    check("imp_even_count", 32'(nout), 32'd4);
    run_impulse(5, ones, nout);
    check("imp_odd_ones", 32'(ones), 32'd0);
    check("imp_odd_count", 32'(nout), 32'd4);

`ifdef AXIS_DECIMATOR_TLAST_EN
    // ---- TLAST framing: FRAME_LEN=3, DECIM=2, 12 inputs ----
    @(negedge clk);
    rst2 = 1'b0;
    repeat (3) @(negedge clk);
    rst2 = 1'b1;
    @(posedge clk);
    k = 0;
    for (int c = 0; c < 16; c++) begin
      @(negedge clk);
      sv2 = (c < 12);
      sd2 = 16'(c);
      #1;
      if (mv2 && mr2) begin
        check("tlast_data", 32'(md2), 32'(2 * k));
        check("tlast_flag", 32'(ml2), 32'((k % 3) == 2));
        k++;
      end
    end
    sv2 = 1'b0;
    check("tlast_count", 32'(k), 32'd6);
`else
    k = 0;
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
